frame_slot_mgr: RTL and testbench

Parametrised, single-clock frame-store bookkeeper for the SDRAM image buffer. It generates SDRAM write addresses for a stream of incoming SPI pixels and splits them into N fixed-size image slots. It tracks which slots are complete, raises image_loaded after a programmable settle delay, and turns a slot-select request into the read base/max address pair plus a load_new pulse for the MTL read side.

---
 rtl/frame_slot_pkg.sv | 30 +++
 rtl/frame_slot_wr_ctr.sv | 58 +++++
 rtl/frame_slot_mgr.sv | 229 ++++++++++++++++++++++
 tb/tb_frame_slot_mgr.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_slot_pkg.sv
// -----------------------------------------------------------------------------
// frame_slot_pkg
// Shared types and constants for the SDRAM frame-store bookkeeper.
//   - state_e      : top-level FSM encoding (IDLE/WRITING/SETTLE/READY)
//   - DEF_*        : default parameter values used by frame_slot_mgr and
//                    frame_slot_wr_ctr
//   - slot_words() : SDRAM words occupied by one image slot
// -----------------------------------------------------------------------------
package frame_slot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITING = 2'd1,
        SETTLE  = 2'd2,
        READY   = 2'd3
    } state_e;

    localparam int DEF_PIX_PER_IMG   = 384000;
    localparam int DEF_WORDS_PER_PIX = 2;
    localparam int DEF_N_SLOTS       = 8;
    localparam int DEF_SETTLE_CYC    = 50;
    localparam int DEF_ADDR_W        = 24;

    // Words per slot; evaluated at elaboration only, so the multiply never
    // reaches the write path.
    function automatic int slot_words(input int pixPerImg, input int wordsPerPix);
        return pixPerImg * wordsPerPix;
    endfunction

endpackage

// File: rtl/frame_slot_wr_ctr.sv
// -----------------------------------------------------------------------------
// frame_slot_wr_ctr
// Write-side counters for the frame store: pixel-in-slot counter, completed
// slot counter and the running SDRAM word address.
// Ports:
//   iCLK, iRST_N  clock / async active-low reset
//   iClear        synchronous restart (priority over iAccept)
//   iAccept       a pixel is accepted this cycle
//   oAddr         word address for the pixel being accepted (pre-increment)
//   oSlot_Cnt     number of fully written slots so far
//   oWrap         combinational: the accepted pixel is the last of its slot
// -----------------------------------------------------------------------------
module frame_slot_wr_ctr
    import frame_slot_pkg::*;
#(
    parameter int PIX_PER_IMG   = DEF_PIX_PER_IMG,
    parameter int WORDS_PER_PIX = DEF_WORDS_PER_PIX,
    parameter int N_SLOTS       = DEF_N_SLOTS,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic                         iClear,
    input  logic                         iAccept,
    output logic [ADDR_W-1:0]            oAddr,
    output logic [$clog2(N_SLOTS+1)-1:0] oSlot_Cnt,
    output logic                         oWrap
);

    localparam int PW = (PIX_PER_IMG > 1) ? $clog2(PIX_PER_IMG) : 1;
    localparam int SW = $clog2(N_SLOTS + 1);

    logic [PW-1:0] pixCnt;

    assign oWrap = iAccept && (pixCnt == PW'(PIX_PER_IMG - 1));

    // Address advances by a constant stride: an adder, no multiplier.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pixCnt    <= '0;
            oSlot_Cnt <= '0;
            oAddr     <= '0;
        end else if (iClear) begin
            pixCnt    <= '0;
            oSlot_Cnt <= '0;
            oAddr     <= '0;
        end else if (iAccept) begin
            oAddr <= oAddr + ADDR_W'(WORDS_PER_PIX);
            if (oWrap) begin
                pixCnt    <= '0;
                oSlot_Cnt <= oSlot_Cnt + SW'(1);
            end else begin
                pixCnt <= pixCnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_slot_mgr.sv
// -----------------------------------------------------------------------------
// frame_slot_mgr
// Frame-store bookkeeper for the SDRAM image buffer. Generates write
// addresses for incoming SPI pixels, splits them into N_SLOTS image slots,
// tracks completed slots, raises oImg_Loaded after a settle delay, and
// converts slot-select requests into a read base/max pair for the MTL side.
//
// Ports:
//   iCLK, iRST_N   clock / async active-low reset
//   iClear         synchronous restart, same effect as reset, top priority
//   iImg_Tot       images to receive (clamped to N_SLOTS when latched)
//   iWr_Valid      pixel strobe;  iPix_Data  RGB pixel (checksum only)
//   oWr_En/oWr_Addr  registered write strobe and word address (latency 1)
//   iSel_Req/iSel_Img  read-slot select
//   oRd_Base/oRd_Max   read window of the selected slot
//   oLoad_New      one-cycle pulse when the read window updates
//   oSel_Err       one-cycle pulse on a rejected select
//   oSlot_Valid    bit k = slot k fully written
//   oImg_Loaded    all images written and settled
//   oOverflow      sticky: pixel arrived after all slots were full
//   oLast_Sum      checksum of the last completed slot
//
// Build option: define FRAME_SLOT_CHECKSUM_EN to enable the per-slot 24-bit
// pixel checksum on oLast_Sum; otherwise oLast_Sum is tied to 0.
// -----------------------------------------------------------------------------
module frame_slot_mgr
    import frame_slot_pkg::*;
#(
    parameter int PIX_PER_IMG   = DEF_PIX_PER_IMG,
    parameter int WORDS_PER_PIX = DEF_WORDS_PER_PIX,
    parameter int N_SLOTS       = DEF_N_SLOTS,
    parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic                         iClear,
    input  logic [$clog2(N_SLOTS+1)-1:0] iImg_Tot,
    input  logic                         iWr_Valid,
    input  logic [23:0]                  iPix_Data,
    output logic                         oWr_En,
    output logic [ADDR_W-1:0]            oWr_Addr,
    input  logic                         iSel_Req,
    input  logic [$clog2(N_SLOTS)-1:0]   iSel_Img,
    output logic [ADDR_W-1:0]            oRd_Base,
    output logic [ADDR_W-1:0]            oRd_Max,
    output logic                         oLoad_New,
    output logic                         oSel_Err,
    output logic [N_SLOTS-1:0]           oSlot_Valid,
    output logic                         oImg_Loaded,
    output logic                         oOverflow,
    output logic [23:0]                  oLast_Sum
);

    localparam int SW         = $clog2(N_SLOTS + 1);
    localparam int IW         = $clog2(N_SLOTS);
    localparam int SLOT_WORDS = slot_words(PIX_PER_IMG, WORDS_PER_PIX);
    localparam int STW        = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    // Elaboration-time sanity checks.
    if (N_SLOTS < 2) begin : g_err_slots
        $error("frame_slot_mgr: N_SLOTS must be at least 2");
    end
    if ((longint'(N_SLOTS) * longint'(SLOT_WORDS)) > (longint'(1) << ADDR_W)) begin : g_err_addr
        $error("frame_slot_mgr: N_SLOTS*SLOT_WORDS exceeds the ADDR_W address space");
    end

    state_e            state, stateNxt;
    logic [SW-1:0]     totLat;
    logic [SW-1:0]     totIn;
    logic [SW-1:0]     totEff;
    logic [SW-1:0]     slotCnt;
    logic [ADDR_W-1:0] ctrAddr;
    logic              wrap;
    logic              accept;
    logic              lastSlot;
    logic [STW-1:0]    settleCnt;
    logic [N_SLOTS-1:0] slotMask;
    logic              selValid;
    logic              selOk;
    logic [ADDR_W-1:0] selBase;

    // Pixels are taken in IDLE (first pixel of a run, only with a non-zero
    // image count) and throughout WRITING; SETTLE/READY drop them.
    assign accept = iWr_Valid &&
                    (((state == IDLE) && (iImg_Tot != '0)) || (state == WRITING));

    frame_slot_wr_ctr #(
        .PIX_PER_IMG   (PIX_PER_IMG),
        .WORDS_PER_PIX (WORDS_PER_PIX),
        .N_SLOTS       (N_SLOTS),
        .ADDR_W        (ADDR_W)
    ) u_wr_ctr (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iClear    (iClear),
        .iAccept   (accept),
        .oAddr     (ctrAddr),
        .oSlot_Cnt (slotCnt),
        .oWrap     (wrap)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else if (iClear) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        totIn    = (iImg_Tot > SW'(N_SLOTS)) ? SW'(N_SLOTS) : iImg_Tot;
        // The first pixel is accepted in IDLE before totLat is written, so
        // the completion compare must use the incoming value there.
        totEff   = (state == IDLE) ? totIn : totLat;
        lastSlot = wrap && ((slotCnt + SW'(1)) == totEff);
        stateNxt = state;
        case (state)
            IDLE:    if (accept) stateNxt = WRITING;
            WRITING: stateNxt = WRITING;
            SETTLE:  if (settleCnt == STW'(SETTLE_CYC)) stateNxt = READY;
            READY:   stateNxt = READY;
            default: stateNxt = IDLE;
        endcase
        if (lastSlot) stateNxt = SETTLE;
    end

    assign oImg_Loaded = (state == READY);

    // ------------------------------------------------- write-side registers
    always_comb begin
        slotMask = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            slotMask[k] = (slotCnt == SW'(k));
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            totLat      <= '0;
            settleCnt   <= '0;
            oWr_En      <= 1'b0;
            oWr_Addr    <= '0;
            oSlot_Valid <= '0;
            oOverflow   <= 1'b0;
        end else if (iClear) begin
            totLat      <= '0;
            settleCnt   <= '0;
            oWr_En      <= 1'b0;
            oWr_Addr    <= '0;
            oSlot_Valid <= '0;
            oOverflow   <= 1'b0;
        end else begin
            if ((state == IDLE) && accept) totLat <= totIn;
            // Counts SETTLE cycles; SETTLE lasts SETTLE_CYC+1 cycles in all.
            if ((state == SETTLE) && (stateNxt == SETTLE)) settleCnt <= settleCnt + STW'(1);
            else                                           settleCnt <= '0;
            oWr_En <= accept;
            if (accept) oWr_Addr <= ctrAddr;
            // Slot valid appears together with the wrap pixel's oWr_En.
            if (wrap) oSlot_Valid <= oSlot_Valid | slotMask;
            if (iWr_Valid && ((state == SETTLE) || (state == READY))) oOverflow <= 1'b1;
        end
    end

    // ---------------------------------------------------------- select path
    // Validity is sampled before this cycle's wrap update, so selecting the
    // slot that completes in the same cycle is rejected.
    always_comb begin
        selValid = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (iSel_Img == IW'(k)) selValid = oSlot_Valid[k];
        end
        selOk   = iSel_Req && (SW'(iSel_Img) < totLat) && selValid;
        selBase = ADDR_W'(iSel_Img) * ADDR_W'(SLOT_WORDS);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRd_Base  <= '0;
            oRd_Max   <= '0;
            oLoad_New <= 1'b0;
            oSel_Err  <= 1'b0;
        end else if (iClear) begin
            oRd_Base  <= '0;
            oRd_Max   <= '0;
            oLoad_New <= 1'b0;
            oSel_Err  <= 1'b0;
        end else begin
            oLoad_New <= selOk;
            oSel_Err  <= iSel_Req && !selOk;
            if (selOk) begin
                oRd_Base <= selBase;
                oRd_Max  <= selBase + ADDR_W'(SLOT_WORDS);
            end
        end
    end

    // ------------------------------------------------------- slot checksum
`ifdef FRAME_SLOT_CHECKSUM_EN
    logic [23:0] runSum;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            runSum    <= '0;
            oLast_Sum <= '0;
        end else if (iClear) begin
            runSum    <= '0;
            oLast_Sum <= '0;
        end else if (accept) begin
            if (wrap) begin
                // The wrap pixel belongs to the slot being closed.
                oLast_Sum <= runSum + iPix_Data;
                runSum    <= '0;
            end else begin
                runSum <= runSum + iPix_Data;
            end
        end
    end
`else
    logic unusedPix;
    assign unusedPix = ^iPix_Data;
    assign oLast_Sum = '0;
`endif

endmodule

// File: tb/tb_frame_slot_mgr.sv
// -----------------------------------------------------------------------------
// tb_frame_slot_mgr
// Self-checking bench for frame_slot_mgr (PIX_PER_IMG=4, WORDS_PER_PIX=2,
// N_SLOTS=4, SETTLE_CYC=3). A hand-computed vector table covers the main
// write/settle/overflow/select flow, hand sequences cover async reset and
// image-count clamping, and a random phase compares every cycle against a
// transaction-level model (pixel count, slot arithmetic, settle deadline).
// -----------------------------------------------------------------------------
module tb_frame_slot_mgr;

    localparam int PIX   = 4;
    localparam int WPP   = 2;
    localparam int NS    = 4;
    localparam int SET   = 3;
    localparam int AW    = 24;
    localparam int SLOTW = PIX * WPP;
`ifdef FRAME_SLOT_CHECKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    logic          iCLK = 1'b0;
    logic          iRST_N;
    logic          iClear;
    logic [2:0]    iImg_Tot;
    logic          iWr_Valid;
    logic [23:0]   iPix_Data;
    logic          oWr_En;
    logic [AW-1:0] oWr_Addr;
    logic          iSel_Req;
    logic [1:0]    iSel_Img;
    logic [AW-1:0] oRd_Base;
    logic [AW-1:0] oRd_Max;
    logic          oLoad_New;
    logic          oSel_Err;
    logic [NS-1:0] oSlot_Valid;
    logic          oImg_Loaded;
    logic          oOverflow;
    logic [23:0]   oLast_Sum;

    always #5 iCLK = ~iCLK;

    frame_slot_mgr #(
        .PIX_PER_IMG   (PIX),
        .WORDS_PER_PIX (WPP),
        .N_SLOTS       (NS),
        .SETTLE_CYC    (SET),
        .ADDR_W        (AW)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iClear      (iClear),
        .iImg_Tot    (iImg_Tot),
        .iWr_Valid   (iWr_Valid),
        .iPix_Data   (iPix_Data),
        .oWr_En      (oWr_En),
        .oWr_Addr    (oWr_Addr),
        .iSel_Req    (iSel_Req),
        .iSel_Img    (iSel_Img),
        .oRd_Base    (oRd_Base),
        .oRd_Max     (oRd_Max),
        .oLoad_New   (oLoad_New),
        .oSel_Err    (oSel_Err),
        .oSlot_Valid (oSlot_Valid),
        .oImg_Loaded (oImg_Loaded),
        .oOverflow   (oOverflow),
        .oLast_Sum   (oLast_Sum)
    );

    typedef struct {
        bit clr; bit wv; int tot; bit sr; int si; int pix;
    } stim_t;

    typedef struct {
        stim_t s;
        bit en; int addr; int sv; bit ld; bit ovf; bit ln; bit se;
        int base; int mx; int sum;
    } vec_t;

    int nVec = 0;
    int nBad = 0;

    // ------------------------------------------------------------- model
    int mTot, mN, mDone, mCyc;
    int curSlot[$];
    bit eEn, eLd, eOvf, eLn, eSe;
    int eAddr, eSv, eBase, eMax, eSum;

    task automatic modelReset();
        mTot = 0; mN = 0; mDone = -1;
        curSlot.delete();
        eEn = 0; eLd = 0; eOvf = 0; eLn = 0; eSe = 0;
        eAddr = 0; eSv = 0; eBase = 0; eMax = 0; eSum = 0;
    endtask

    // One clock edge with inputs s: pixels are numbered, slots are
    // pixel-count / PIX, the run is done at mTot*PIX pixels and loaded
    // SET+1 edges after the last accepted pixel.
    task automatic modelEdge(input stim_t s);
        int preSlots;
        bit full;
        int acc;
        if (s.clr) begin
            modelReset();
            mCyc++;
            return;
        end
        preSlots = mN / PIX;
        full = (mTot != 0) && (mN == mTot * PIX);
        eLn = 0; eSe = 0;
        if (s.sr) begin
            if (s.si < mTot && s.si < preSlots) begin
                eLn = 1; eBase = s.si * SLOTW; eMax = eBase + SLOTW;
            end else begin
                eSe = 1;
            end
        end
        eEn = 0;
        if (s.wv) begin
            if (full) begin
                eOvf = 1;
            end else if (mTot != 0 || s.tot != 0) begin
                if (mTot == 0) mTot = (s.tot > NS) ? NS : s.tot;
                eEn = 1;
                eAddr = mN * WPP;
                mN++;
                curSlot.push_back(s.pix);
                if (mN % PIX == 0) begin
                    acc = 0;
                    foreach (curSlot[i]) acc += curSlot[i];
                    if (CKSUM) eSum = acc & 24'hFFFFFF;
                    curSlot.delete();
                end
                if (mN == mTot * PIX) mDone = mCyc;
            end
        end
        eSv = (1 << (mN / PIX)) - 1;
        eLd = (mDone >= 0) && (mCyc >= mDone + SET + 1);
        mCyc++;
    endtask

    // ---------------------------------------------------------- checking
    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        nVec++;
        if (act !== 32'(exp)) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmpModel(input string tag);
        chk({tag, ".wr_en"}, 32'(oWr_En), int'(eEn));
        if (eEn || mN == 0) chk({tag, ".wr_addr"}, 32'(oWr_Addr), eAddr);
        chk({tag, ".slot_valid"}, 32'(oSlot_Valid), eSv);
        chk({tag, ".img_loaded"}, 32'(oImg_Loaded), int'(eLd));
        chk({tag, ".overflow"}, 32'(oOverflow), int'(eOvf));
        chk({tag, ".load_new"}, 32'(oLoad_New), int'(eLn));
        chk({tag, ".sel_err"}, 32'(oSel_Err), int'(eSe));
        chk({tag, ".rd_base"}, 32'(oRd_Base), eBase);
        chk({tag, ".rd_max"}, 32'(oRd_Max), eMax);
        chk({tag, ".last_sum"}, 32'(oLast_Sum), eSum);
    endtask

    task automatic chkZero(input string tag);
        chk({tag, ".wr_en"}, 32'(oWr_En), 0);
        chk({tag, ".wr_addr"}, 32'(oWr_Addr), 0);
        chk({tag, ".slot_valid"}, 32'(oSlot_Valid), 0);
        chk({tag, ".img_loaded"}, 32'(oImg_Loaded), 0);
        chk({tag, ".overflow"}, 32'(oOverflow), 0);
        chk({tag, ".load_new"}, 32'(oLoad_New), 0);
        chk({tag, ".sel_err"}, 32'(oSel_Err), 0);
        chk({tag, ".rd_base"}, 32'(oRd_Base), 0);
        chk({tag, ".rd_max"}, 32'(oRd_Max), 0);
        chk({tag, ".last_sum"}, 32'(oLast_Sum), 0);
    endtask

    function automatic stim_t mk(bit clr, bit wv, int tot, bit sr, int si, int pix);
        stim_t s;
        s.clr = clr; s.wv = wv; s.tot = tot; s.sr = sr; s.si = si; s.pix = pix;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        iClear    = s.clr;
        iWr_Valid = s.wv;
        iImg_Tot  = 3'(s.tot);
        iSel_Req  = s.sr;
        iSel_Img  = 2'(s.si);
        iPix_Data = 24'(s.pix);
    endtask

    task automatic step(input stim_t s);
        drive(s);
        @(posedge iCLK);
        modelEdge(s);
        #1;
        cmpModel("mdl");
    endtask

    // Table row: image count fixed at 2, no clear.
    function automatic vec_t row(bit wv, bit sr, int si, int pix,
                                 bit en, int addr, int sv, bit ld, bit ovf,
                                 bit ln, bit se, int base, int mx, int sum);
        vec_t v;
        v.s = mk(1'b0, wv, 2, sr, si, pix);
        v.en = en; v.addr = addr; v.sv = sv; v.ld = ld; v.ovf = ovf;
        v.ln = ln; v.se = se; v.base = base; v.mx = mx; v.sum = sum;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Two images of 4 pixels, overflow, then selects (hand-derived).
        //             wv sr si pix  en addr sv   ld ovf ln se base max sum
        tbl.push_back(row(1, 0, 0, 1,  1,  0, 4'b0000, 0, 0, 0, 0, 0,  0,  0));
        tbl.push_back(row(1, 0, 0, 2,  1,  2, 4'b0000, 0, 0, 0, 0, 0,  0,  0));
        tbl.push_back(row(1, 0, 0, 3,  1,  4, 4'b0000, 0, 0, 0, 0, 0,  0,  0));
        tbl.push_back(row(1, 1, 0, 4,  1,  6, 4'b0001, 0, 0, 0, 1, 0,  0, 10));
        tbl.push_back(row(1, 1, 0, 5,  1,  8, 4'b0001, 0, 0, 1, 0, 0,  8, 10));
        tbl.push_back(row(1, 0, 0, 6,  1, 10, 4'b0001, 0, 0, 0, 0, 0,  8, 10));
        tbl.push_back(row(1, 0, 0, 7,  1, 12, 4'b0001, 0, 0, 0, 0, 0,  8, 10));
        tbl.push_back(row(1, 0, 0, 8,  1, 14, 4'b0011, 0, 0, 0, 0, 0,  8, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 0, 0, 0, 0, 0,  8, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 0, 0, 0, 0, 0,  8, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 0, 0, 0, 0, 0,  8, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 1, 0, 0, 0, 0,  8, 26));
        tbl.push_back(row(1, 0, 0, 9,  0,  0, 4'b0011, 1, 1, 0, 0, 0,  8, 26));
        tbl.push_back(row(1, 0, 0, 10, 0,  0, 4'b0011, 1, 1, 0, 0, 0,  8, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 1, 1, 0, 0, 0,  8, 26));
        tbl.push_back(row(0, 1, 1, 0,  0,  0, 4'b0011, 1, 1, 1, 0, 8, 16, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 1, 1, 0, 0, 8, 16, 26));
        tbl.push_back(row(0, 1, 3, 0,  0,  0, 4'b0011, 1, 1, 0, 1, 8, 16, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 1, 1, 0, 0, 8, 16, 26));
        tbl.push_back(row(0, 1, 2, 0,  0,  0, 4'b0011, 1, 1, 0, 1, 8, 16, 26));
        tbl.push_back(row(0, 1, 0, 0,  0,  0, 4'b0011, 1, 1, 1, 0, 0,  8, 26));
        tbl.push_back(row(0, 0, 0, 0,  0,  0, 4'b0011, 1, 1, 0, 0, 0,  8, 26));

        mCyc = 0;
        modelReset();
        iRST_N = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge iCLK);
        #1;
        chkZero("reset");
        @(negedge iCLK);
        iRST_N = 1'b1;

        // ---- table: write flow, settle, overflow, selects, checksum
        foreach (tbl[i]) begin
            step(tbl[i].s);
            chk($sformatf("tbl%0d.wr_en", i), 32'(oWr_En), int'(tbl[i].en));
            if (tbl[i].en) chk($sformatf("tbl%0d.wr_addr", i), 32'(oWr_Addr), tbl[i].addr);
            chk($sformatf("tbl%0d.slot_valid", i), 32'(oSlot_Valid), tbl[i].sv);
            chk($sformatf("tbl%0d.img_loaded", i), 32'(oImg_Loaded), int'(tbl[i].ld));
            chk($sformatf("tbl%0d.overflow", i), 32'(oOverflow), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d.load_new", i), 32'(oLoad_New), int'(tbl[i].ln));
            chk($sformatf("tbl%0d.sel_err", i), 32'(oSel_Err), int'(tbl[i].se));
            chk($sformatf("tbl%0d.rd_base", i), 32'(oRd_Base), tbl[i].base);
            chk($sformatf("tbl%0d.rd_max", i), 32'(oRd_Max), tbl[i].mx);
            chk($sformatf("tbl%0d.last_sum", i), 32'(oLast_Sum), CKSUM ? tbl[i].sum : 0);
        end

        // ---- iClear restarts everything
        step(mk(1, 1, 2, 1, 1, 0));
        chkZero("clear");

        // ---- async reset in the middle of WRITING (pixel 5)
        for (int p = 1; p <= 5; p++) step(mk(0, 1, 2, 0, 0, p));
        chk("arst.pre_addr", 32'(oWr_Addr), 8);
        #2;
        iRST_N = 1'b0;
        #1;
        chkZero("arst");
        modelReset();
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        step(mk(0, 1, 2, 0, 0, 7));
        chk("arst.first_en", 32'(oWr_En), 1);
        chk("arst.first_addr", 32'(oWr_Addr), 0);

        // ---- image count above N_SLOTS clamps to 4 slots
        step(mk(1, 0, 0, 0, 0, 0));
        for (int p = 1; p <= 16; p++) step(mk(0, 1, 7, 0, 0, p));
        chk("clamp.slot_valid", 32'(oSlot_Valid), 4'b1111);
        chk("clamp.last_addr", 32'(oWr_Addr), 30);
        for (int c = 1; c <= 4; c++) begin
            step(mk(0, 0, 7, 0, 0, 0));
            chk($sformatf("clamp.loaded_c%0d", c), 32'(oImg_Loaded), (c == 4) ? 1 : 0);
        end
        chk("clamp.ovf_before", 32'(oOverflow), 0);
        step(mk(0, 1, 7, 0, 0, 17));
        chk("clamp.ovf_after", 32'(oOverflow), 1);
        chk("clamp.en_dropped", 32'(oWr_En), 0);
        step(mk(0, 0, 7, 1, 3, 0));
        chk("clamp.sel3_base", 32'(oRd_Base), 24);
        chk("clamp.sel3_max", 32'(oRd_Max), 32);

        // ---- randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            stim_t s;
            s.clr = ($urandom_range(0, 149) == 0);
            s.wv  = ($urandom_range(0, 9) < 8);
            s.tot = $urandom_range(0, 7);
            s.sr  = ($urandom_range(0, 4) == 0);
            s.si  = $urandom_range(0, 3);
            s.pix = int'($urandom & 32'h00FF_FFFF);
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
